// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/sequencing controller: load-use, EX-resolved branch/jump flush,
// multi-cycle mul/div busy tracking and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 3,
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_md_start,
  input  logic              id_reads_hilo,
  input  logic              ex_memr,
  input  logic [4:0]        ex_rd,
  input  logic              ex_branch_taken,
  input  logic              ex_jump,
  output logic              pc_wr,
  output logic              if_id_wr,
  output logic              if_id_flush,
  output logic              id_ex_stall,
  output logic              id_ex_flush,
  output logic              md_busy,
  output logic [PERF_W-1:0] stall_cnt
);

  typedef enum logic {RUN, MD} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   md_cnt_q, md_cnt_d;
  logic [PERF_W-1:0]  stall_cnt_q;
  logic               lu, md_haz, flush, stall, issue;

  assign md_busy   = (md_cnt_q != '0);
  assign stall_cnt = stall_cnt_q;

  assign lu = ex_memr && (ex_rd != 5'd0) &&
              ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
  assign md_haz = md_busy && (id_reads_hilo || id_md_start);
  assign flush  = ex_branch_taken || ex_jump;
  assign stall  = !flush && (lu || md_haz);
  // A flushed or stalled md_start is simply dropped; it will re-present later if still valid.
  assign issue  = id_md_start && !flush && !stall;

  always_comb begin
    pc_wr       = 1'b1;
    if_id_wr    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_stall = 1'b0;
    id_ex_flush = 1'b0;
    if (!rst) begin
      if (flush) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (stall) begin
        pc_wr       = 1'b0;
        if_id_wr    = 1'b0;
        id_ex_stall = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    case (state_q)
      RUN: begin
        if (issue) begin
          md_cnt_d = CNT_W'(MD_LAT);
          state_d  = MD;
        end
      end
      MD: begin
        // Flushes do not cancel the op already in EX; keep counting down.
        md_cnt_d = md_cnt_q - CNT_W'(1);
        if (md_cnt_q == CNT_W'(1)) state_d = RUN;
      end
      default: begin
        state_d  = RUN;
        md_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
      if (id_ex_stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + PERF_W'(1);
    end
  end

endmodule
